// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM controller.
//   - sd_cmd_t : command encoding on {cs_n, ras_n, cas_n, we_n}
//   - state_t  : controller sequencing states
//   - address field widths / slice positions of the 24-bit request address
//   - mode_reg(): builds the MRS operand for a given CAS latency
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_MRS  = 4'b0000,
        CMD_REF  = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_BST  = 4'b0110,
        CMD_NOP  = 4'b0111,
        CMD_DESL = 4'b1111
    } sd_cmd_t;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PALL,
        ST_INIT_REF,
        ST_INIT_MRS,
        ST_INIT_FIN,
        ST_IDLE,
        ST_ACT,
        ST_RW,
        ST_WAIT
    } state_t;

    localparam int ADDR_W  = 24;
    localparam int BA_W    = 2;
    localparam int ROW_W   = 13;
    localparam int COL_W   = 9;
    localparam int DQ_W    = 16;
    localparam int DQM_W   = 2;
    localparam int COL_LSB = 0;
    localparam int ROW_LSB = COL_LSB + COL_W;
    localparam int BA_LSB  = ROW_LSB + ROW_W;
    localparam int AP_BIT  = 10;   // auto-precharge / precharge-all bit

    // Burst length 1, sequential, CAS latency in [6:4], standard write burst.
    function automatic logic [ROW_W-1:0] mode_reg(input int cas_lat);
        logic [ROW_W-1:0] m;
        m      = '0;
        m[6:4] = 3'(cas_lat);
        return m;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh request generator.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : start the timer (one pulse when initialization finishes)
//   clear      : a REF has been issued; drop the pending flag
//   expire     : counter is at 0 this cycle (pending sets on the next edge)
//   pending    : a refresh is owed
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic expire,
    output logic pending
);

    localparam int CW = $clog2(REF_INTERVAL + 1);

    logic [CW-1:0] cnt;
    logic          active;

    assign expire = active && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            active  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                cnt    <= CW'(REF_INTERVAL - 1);
                active <= 1'b1;
            end else if (active) begin
                // reload on the zero cycle, so the counter never wraps below 0
                if (cnt == '0) cnt <= CW'(REF_INTERVAL - 1);
                else           cnt <= cnt - CW'(1);
            end
            // single flag: an expiry while already pending is absorbed
            if (expire)     pending <= 1'b1;
            else if (clear) pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-word SDRAM controller (16-bit, 4 banks, 13-bit row,
// 9-bit column). Runs power-up init, periodic CBR refresh, and turns each
// CPU request into ACT + READA/WRITA.
//   CPU side : req_valid/req_ready/req_we/req_addr/req_wdata/req_wmask,
//              rsp_valid/rsp_rdata, init_done
//   Pad side : sd_cke, sd_cs_n/ras_n/cas_n/we_n, sd_ba, sd_addr, sd_dqm,
//              sd_dq_out/sd_dq_oe, sd_dq_in
module sdram_ctrl
    import sdram_pkg::*;
#(
    parameter int INIT_CYCLES  = 20000,
    parameter int REF_INTERVAL = 780,
    parameter int INIT_REFS    = 8,
    parameter int T_RP         = 2,
    parameter int T_RCD        = 2,
    parameter int T_RC         = 7,
    parameter int T_WR         = 2,
    parameter int T_MRD        = 2,
    parameter int CAS_LAT      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DQ_W-1:0]   req_wdata,
    input  logic [DQM_W-1:0]  req_wmask,
    output logic              rsp_valid,
    output logic [DQ_W-1:0]   rsp_rdata,
    output logic              init_done,
    output logic              sd_cke,
    output logic              sd_cs_n,
    output logic              sd_ras_n,
    output logic              sd_cas_n,
    output logic              sd_we_n,
    output logic [BA_W-1:0]   sd_ba,
    output logic [ROW_W-1:0]  sd_addr,
    output logic [DQM_W-1:0]  sd_dqm,
    output logic [DQ_W-1:0]   sd_dq_out,
    output logic              sd_dq_oe,
    input  logic [DQ_W-1:0]   sd_dq_in
);

    // Wait counter must cover the power-up wait; the short timing waits
    // (all well under 64 clocks) fit trivially.
    localparam int CNT_W   = $clog2(INIT_CYCLES + 64);
    localparam int RC_W    = $clog2(INIT_REFS + 1);
    // Return-to-idle point measured from ACT: the later of tRC and the
    // access finishing (read data returned / write recovered + precharged).
    localparam int RD_DONE = T_RCD + CAS_LAT + 1;
    localparam int WR_DONE = T_RCD + T_WR + T_RP;
    localparam int RD_END  = (T_RC > RD_DONE) ? T_RC : RD_DONE;
    localparam int WR_END  = (T_RC > WR_DONE) ? T_RC : WR_DONE;

    state_t              state;
    sd_cmd_t             cmd;
    logic [CNT_W-1:0]    cnt;
    logic [RC_W-1:0]     ref_cnt;
    logic                rq_we;
    logic [ADDR_W-1:0]   rq_addr;
    logic [DQ_W-1:0]     rq_wdata;
    logic [DQM_W-1:0]    rq_wmask;
    logic [CAS_LAT:0]    rd_pipe;   // bit k set k clocks after READA
    logic [DQ_W-1:0]     cap_data;
    logic                ref_pending;
    logic                ref_expire;
    logic                init_fin;
    logic                ref_issue;

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd;

    assign init_fin  = (state == ST_INIT_FIN) && (cnt == '0);
    assign ref_issue = (state == ST_IDLE) && ref_pending;
    // Holding ready low on the expiry cycle lets refresh win a tie.
    assign req_ready = (state == ST_IDLE) && !ref_pending && !ref_expire;

    sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (init_fin),
        .clear   (ref_issue),
        .expire  (ref_expire),
        .pending (ref_pending)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT_WAIT;
            cmd       <= CMD_DESL;
            cnt       <= '0;
            ref_cnt   <= '0;
            sd_cke    <= 1'b0;
            sd_ba     <= '0;
            sd_addr   <= '0;
            sd_dqm    <= '1;
            sd_dq_out <= '0;
            sd_dq_oe  <= 1'b0;
            init_done <= 1'b0;
            rq_we     <= 1'b0;
            rq_addr   <= '0;
            rq_wdata  <= '0;
            rq_wmask  <= '0;
            rd_pipe   <= '0;
            cap_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // defaults: one-cycle commands, bus idle
            sd_cke   <= 1'b1;
            cmd      <= CMD_NOP;
            sd_ba    <= '0;
            sd_addr  <= '0;
            sd_dqm   <= '1;
            sd_dq_oe <= 1'b0;

            rd_pipe <= {rd_pipe[CAS_LAT-1:0], 1'b0};
            if (rd_pipe[CAS_LAT-1]) cap_data <= sd_dq_in;
            rsp_valid <= rd_pipe[CAS_LAT];
            if (rd_pipe[CAS_LAT]) rsp_rdata <= cap_data;

            if (state == ST_INIT_WAIT) begin
                if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= ST_INIT_PALL;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                // a command issued at cycle c with cnt=T-1 lets the next
                // action happen at c+T
                case (state)
                    ST_INIT_PALL: begin
                        cmd             <= CMD_PRE;
                        sd_addr[AP_BIT] <= 1'b1;
                        cnt             <= CNT_W'(T_RP - 1);
                        ref_cnt         <= '0;
                        state           <= ST_INIT_REF;
                    end
                    ST_INIT_REF: begin
                        cmd     <= CMD_REF;
                        cnt     <= CNT_W'(T_RC - 1);
                        ref_cnt <= ref_cnt + RC_W'(1);
                        if (ref_cnt == RC_W'(INIT_REFS - 1)) state <= ST_INIT_MRS;
                    end
                    ST_INIT_MRS: begin
                        cmd     <= CMD_MRS;
                        sd_addr <= mode_reg(CAS_LAT);
                        cnt     <= CNT_W'(T_MRD - 1);
                        state   <= ST_INIT_FIN;
                    end
                    ST_INIT_FIN: begin
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (ref_pending) begin
                            cmd   <= CMD_REF;
                            cnt   <= CNT_W'(T_RC - 1);
                            state <= ST_WAIT;
                        end else if (req_valid && !ref_expire) begin
                            rq_we    <= req_we;
                            rq_addr  <= req_addr;
                            rq_wdata <= req_wdata;
                            rq_wmask <= req_wmask;
                            state    <= ST_ACT;
                        end
                    end
                    ST_ACT: begin
                        cmd     <= CMD_ACT;
                        sd_ba   <= rq_addr[BA_LSB +: BA_W];
                        sd_addr <= rq_addr[ROW_LSB +: ROW_W];
                        cnt     <= CNT_W'(T_RCD - 1);
                        state   <= ST_RW;
                    end
                    ST_RW: begin
                        sd_ba   <= rq_addr[BA_LSB +: BA_W];
                        sd_addr <= {3'b001, 1'b0, rq_addr[COL_LSB +: COL_W]};
                        state   <= ST_WAIT;
                        if (rq_we) begin
                            cmd       <= CMD_WR;
                            sd_dq_out <= rq_wdata;
                            sd_dq_oe  <= 1'b1;
                            sd_dqm    <= ~rq_wmask;
                            cnt       <= CNT_W'(WR_END - T_RCD - 1);
                        end else begin
                            cmd        <= CMD_RD;
                            sd_dqm     <= '0;
                            rd_pipe[0] <= 1'b1;
                            cnt        <= CNT_W'(RD_END - T_RCD - 1);
                        end
                    end
                    ST_WAIT: state <= ST_IDLE;
                    default: state <= ST_INIT_WAIT;
                endcase
            end
        end
    end

endmodule

// File: doc/sdram_ctrl.md
Name: sdram_ctrl

Overview:
- Sequences the 16-bit, 4-bank SDRAM device with 13-bit row and 9-bit column addressing.
- Performs the power-up initialization: wait, PALL, 8 auto-refreshes, mode register set.
- Schedules periodic CBR refreshes.
- Converts single-word read/write requests from the CPU memory port into ACT + READA/WRITA command sequences on the SDRAM pins.
- Sits between the CPU load/store/fetch path and the SDRAM pad ring.

Parameters:
- INIT_CYCLES, 20000, power-up wait in clocks (200 us at 100 MHz).
- REF_INTERVAL, 780, clocks between refresh commands (7.8 us).
- INIT_REFS, 8, auto-refresh count during init.
- T_RP, 2, precharge-to-command clocks.
- T_RCD, 2, ACT-to-READ/WRITE clocks.
- T_RC, 7, ACT-to-ACT and REF-to-command clocks.
- T_WR, 2, write-recovery clocks before auto-precharge starts.
- T_MRD, 2, MRS-to-command clocks.
- CAS_LAT, 2, CAS latency; only 2 or 3 are legal.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  24  {bank[23:22], row[21:9], col[8:0]}
- req_wdata  in  16  write data
- req_wmask  in  2  byte enables, 1 = write byte; drives sd_dqm as the inverse
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  16  read data
- init_done  out  1  initialization complete
- sd_cke  out  1  clock enable
- sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  out  1 each  command pins
- sd_ba  out  2  bank address
- sd_addr  out  13  row/column/mode address
- sd_dqm  out  2  byte data mask
- sd_dq_out  out  16  write data to pad
- sd_dq_oe  out  1  pad output enable
- sd_dq_in  in  16  read data from pad

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low (rst_n); it is sampled only on the rising edge of clk.
- Reset values:
  - command pins = DESL (cs_n=1), sd_cke=0, sd_dqm=2'b11, sd_dq_oe=0.
  - req_ready=0, rsp_valid=0, init_done=0.
  - All counters 0; state INIT_WAIT.
- Command timing: every command is driven for exactly one clock. All non-command cycles drive NOP (0111). Command pins are registered outputs.
- Init sequence:
  - INIT_WAIT: sd_cke=1 from first post-reset cycle; NOP for INIT_CYCLES clocks.
  - INIT_PALL: PALL (sd_addr[10]=1), then T_RP clocks.
  - INIT_REF: REF then T_RC clocks, repeated INIT_REFS times.
  - INIT_MRS: MRS with sd_ba=0 and sd_addr = 13'b000_0_00_CL_0_000, i.e. burst length 1, sequential, CL = 3-bit CAS_LAT. Then T_MRD clocks.
  - Then IDLE with init_done=1; init_done stays 1 until reset.
- Refresh timer:
  - Free-running down-counter, loaded with REF_INTERVAL-1 when init completes.
  - At 0 it sets ref_pending and reloads.
  - ref_pending clears when REF is issued.
  - A second expiry while pending is not counted (single pending flag).
- IDLE arbitration:
  - ref_pending has priority: REF, then T_RC wait, then IDLE.
  - Otherwise req_ready=1. req_ready is combinational from state/ref_pending, not from req_valid.
- Request acceptance:
  - Accepted when req_valid && req_ready. Address, data, mask and we are latched.
  - Acceptance cycle+1: ACT issued with ba = bank, addr = row.
- Read:
  - READA issued T_RCD clocks after ACT, with addr[10]=1, addr[8:0]=col, sd_dqm=00.
  - sd_dq_in sampled CAS_LAT clocks after READA.
  - rsp_rdata/rsp_valid are registered from that sample, so rsp_valid pulses CAS_LAT+1 clocks after READA.
- Write:
  - WRITA issued T_RCD clocks after ACT, with sd_dq_oe=1, sd_dq_out=wdata, sd_dqm=~wmask, for that cycle only.
- Return to IDLE: after max(T_RC from ACT, completion), where completion = rsp_valid cycle for reads, or T_WR+T_RP after WRITA for writes. req_ready stays 0 throughout.
- Outside read/write-issue cycles sd_dqm=2'b11 and sd_dq_oe=0.
- Request and refresh expiring the same cycle in IDLE: refresh wins; req_ready is 0 that cycle.
- Reset mid-operation: immediate return to reset values and full re-init. No rsp_valid is produced for an in-flight read.
- Timer wrap-around: the refresh counter never underflows; reload happens on the 0 cycle.

Decomposition:
- Package sdram_pkg holds:
  - command typedef enum over {cs_n,ras_n,cas_n,we_n}: DESL, NOP, BST, RD, WR, ACT, PRE, REF, MRS;
  - controller state enum;
  - address field widths and slice localparams;
  - mode-register builder function taking CAS_LAT.
- Sub-module: sdram_refresh_timer, containing the down-counter, reload and pending flag, with a clear input.

Test Plan (bench parameters INIT_CYCLES=10, REF_INTERVAL=50):
- Reset release:
  - Exactly 10 NOP clocks, then PALL with addr[10]=1.
  - 8 REFs spaced T_RC=7 apart.
  - MRS with addr=13'h020.
  - init_done rises T_MRD clocks after MRS; req_ready=0 throughout.
- Write 0xBEEF to addr 24'h40_1234, mask 2'b01:
  - ACT with ba=1, row=13'h0009.
  - 2 clocks later WRITA with col=9'h034, addr[10]=1, dq_out=0xBEEF, dqm=2'b10, dq_oe=1 for one cycle.
- Read same address with model returning 0xBEEF on sd_dq_in at the CAS_LAT cycle:
  - rsp_valid pulses once, 3 clocks after READA, with rsp_rdata=0xBEEF.
  - req_ready returns no earlier than 7 clocks after ACT.
- Refresh periodicity with req_valid held low: REF commands exactly 50 clocks apart.
- req_valid asserted on the cycle the refresh timer expires:
  - REF issued first, req_ready=0.
  - Request accepted after the T_RC wait, and its ACT follows.
- rst_n pulsed low for one clock, 1 clock after a READA:
  - No rsp_valid.
  - Command pins show DESL, then the init sequence restarts; init_done=0.
